// File: rtl/layer_featuremap_acc.sv
// Per-pixel channel accumulator: sums CHANNELS conv results LANES at a time,
// adds BIAS, applies the activation, saturates and tracks the pixel position.
module layer_featuremap_acc #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned FRAC_BITS  = 8,
  parameter int unsigned CHANNELS   = 32,
  parameter int unsigned LANES      = 4,
  parameter int unsigned IMG_SIZE   = 104,
  parameter logic signed [DATA_WIDTH-1:0] BIAS = '0,
  parameter int unsigned ACT_MODE   = 0
) (
  input  logic                           Clk,
  input  logic                           Rst,
  input  logic [CHANNELS*DATA_WIDTH-1:0] data_in,
  input  logic                           valid_in,
  output logic                           ready_in,
  output logic [DATA_WIDTH-1:0]          data_out,
  output logic                           valid_out,
  output logic                           frame_done
);

  localparam int unsigned K     = CHANNELS / LANES;
  localparam int unsigned ACC_W = DATA_WIDTH + $clog2(CHANNELS) + 1;
  localparam int unsigned GW    = (K > 1) ? $clog2(K) : 1;
  localparam int unsigned CW    = (IMG_SIZE > 1) ? $clog2(IMG_SIZE) : 1;

  localparam logic [GW-1:0] G_LAST = GW'(K - 1);
  localparam logic [CW-1:0] C_LAST = CW'(IMG_SIZE - 1);
  localparam logic signed [ACC_W-1:0] SAT_MAX =
    {{(ACC_W-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN =
    {{(ACC_W-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  // Reject configurations the lane grouping or fixed-point format cannot support.
  if ((CHANNELS % LANES) != 0 || FRAC_BITS >= DATA_WIDTH) begin : g_bad_cfg
    $error("layer_featuremap_acc: invalid CHANNELS/LANES/FRAC_BITS");
  end

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t                         state_q;
  logic [CHANNELS*DATA_WIDTH-1:0] data_q;
  logic signed [ACC_W-1:0]        acc_q;
  logic [GW-1:0]                  grp_q;
  logic [CW-1:0]                  col_q;
  logic [CW-1:0]                  row_q;

  logic signed [ACC_W-1:0]        group_sum_c;
  logic signed [ACC_W-1:0]        acc_next_c;
  logic signed [ACC_W-1:0]        act_c;
  logic [DATA_WIDTH-1:0]          sat_c;

  assign ready_in = (state_q == IDLE);

  // Sum of the current lane group, then activation and saturation of the running total.
  always_comb begin
    group_sum_c = '0;
    for (int l = 0; l < int'(LANES); l++) begin
      group_sum_c = group_sum_c + ACC_W'($signed(
        data_q[(int'(grp_q) * int'(LANES) + l) * int'(DATA_WIDTH) +: DATA_WIDTH]));
    end
    acc_next_c = acc_q + group_sum_c;

    act_c = acc_next_c;
    if (ACT_MODE == 1 && acc_next_c < 0) begin
      act_c = '0;
    end else if (ACT_MODE == 2 && acc_next_c < 0) begin
      act_c = acc_next_c >>> 3;
    end

    if (act_c > SAT_MAX) begin
      sat_c = SAT_MAX[DATA_WIDTH-1:0];
    end else if (act_c < SAT_MIN) begin
      sat_c = SAT_MIN[DATA_WIDTH-1:0];
    end else begin
      sat_c = act_c[DATA_WIDTH-1:0];
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q    <= IDLE;
      data_q     <= '0;
      acc_q      <= '0;
      grp_q      <= '0;
      col_q      <= '0;
      row_q      <= '0;
      data_out   <= '0;
      valid_out  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      valid_out  <= 1'b0;
      frame_done <= 1'b0;
      case (state_q)
        IDLE: begin
          if (valid_in) begin
            data_q  <= data_in;
            acc_q   <= ACC_W'(BIAS);
            grp_q   <= '0;
            state_q <= ACCUM;
          end
        end
        ACCUM: begin
          acc_q <= acc_next_c;
          grp_q <= grp_q + GW'(1);
          if (grp_q == G_LAST) begin
            state_q    <= DONE;
            data_out   <= sat_c;
            valid_out  <= 1'b1;
            frame_done <= (col_q == C_LAST) && (row_q == C_LAST);
            // Position advances with every emitted pixel, wrapping at frame end.
            if (col_q == C_LAST) begin
              col_q <= '0;
              row_q <= (row_q == C_LAST) ? '0 : row_q + CW'(1);
            end else begin
              col_q <= col_q + CW'(1);
            end
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_layer_featuremap_acc.sv
// Directed bench: three instances (linear+bias, ReLU, leaky) share one stimulus stream.
module tb_layer_featuremap_acc;

  logic        clk;
  logic        rst;
  logic [63:0] data_in;
  logic        valid_in;

  logic        rdy_l, rdy_r, rdy_k;
  logic [15:0] dout_l, dout_r, dout_k;
  logic        vout_l, vout_r, vout_k;
  logic        fd_l, fd_r, fd_k;

  int checks;
  int failures;

  layer_featuremap_acc #(.DATA_WIDTH(16), .FRAC_BITS(8), .CHANNELS(4), .LANES(2),
    .IMG_SIZE(2), .BIAS(16'sh0080), .ACT_MODE(0)) u_lin (
    .Clk(clk), .Rst(rst), .data_in(data_in), .valid_in(valid_in), .ready_in(rdy_l),
    .data_out(dout_l), .valid_out(vout_l), .frame_done(fd_l));

  layer_featuremap_acc #(.DATA_WIDTH(16), .FRAC_BITS(8), .CHANNELS(4), .LANES(2),
    .IMG_SIZE(2), .BIAS(16'sh0000), .ACT_MODE(1)) u_relu (
    .Clk(clk), .Rst(rst), .data_in(data_in), .valid_in(valid_in), .ready_in(rdy_r),
    .data_out(dout_r), .valid_out(vout_r), .frame_done(fd_r));

  layer_featuremap_acc #(.DATA_WIDTH(16), .FRAC_BITS(8), .CHANNELS(4), .LANES(2),
    .IMG_SIZE(2), .BIAS(16'sh0000), .ACT_MODE(2)) u_leaky (
    .Clk(clk), .Rst(rst), .data_in(data_in), .valid_in(valid_in), .ready_in(rdy_k),
    .data_out(dout_k), .valid_out(vout_k), .frame_done(fd_k));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] rep4(input logic [15:0] v);
    return {v, v, v, v};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one pixel, wait for its result (bounded), and return to IDLE.
  task automatic run_pixel(input logic [63:0] d, output logic [15:0] lin,
                           output logic [15:0] relu, output logic [15:0] leaky,
                           output logic fd);
    bit got;
    got = 1'b0;
    lin = '0; relu = '0; leaky = '0; fd = 1'b0;
    data_in  = d;
    valid_in = 1'b1;
    tick();
    valid_in = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      tick();
      if (vout_l) begin
        got = 1'b1;
        lin = dout_l; relu = dout_r; leaky = dout_k; fd = fd_l;
      end
    end
    if (!got) chk("pixel_timeout", 32'd0, 32'd1);
    tick();
  endtask

  logic [15:0] lin, relu, leaky;
  logic        fd;
  logic [15:0] bp_out [3];
  int          bp_cnt;
  logic [3:0]  fd_seen;

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    valid_in = 1'b0;
    data_in  = '0;
    #2;
    chk("reset_ready", 32'(rdy_l), 32'd1);
    chk("reset_valid", 32'(vout_l), 32'd0);
    chk("reset_dout", 32'(dout_l), 32'd0);
    tick();
    tick();
    rst = 1'b0;

    // Bias and latency: 4*0x0100 + 0x0080 = 0x0480, visible in the 3rd cycle after accept.
    data_in  = rep4(16'h0100);
    valid_in = 1'b1;
    tick();
    valid_in = 1'b0;
    chk("lat_c1_ready", 32'(rdy_l), 32'd0);
    chk("lat_c1_valid", 32'(vout_l), 32'd0);
    tick();
    chk("lat_c2_ready", 32'(rdy_l), 32'd0);
    chk("lat_c2_valid", 32'(vout_l), 32'd0);
    tick();
    chk("lat_c3_ready", 32'(rdy_l), 32'd0);
    chk("lat_c3_valid", 32'(vout_l), 32'd1);
    chk("lat_c3_dout", 32'(dout_l), 32'h0480);
    chk("lat_c3_relu", 32'(dout_r), 32'h0400);
    tick();
    chk("lat_c4_ready", 32'(rdy_l), 32'd1);
    chk("lat_c4_valid", 32'(vout_l), 32'd0);
    chk("lat_c4_hold", 32'(dout_l), 32'h0480);

    // Negative sum -1024: leaky -> -128, ReLU -> 0, linear with bias -> -896.
    run_pixel(rep4(16'hFF00), lin, relu, leaky, fd);
    chk("leaky_neg", 32'(leaky), 32'hFF80);
    chk("relu_neg", 32'(relu), 32'h0000);
    chk("lin_neg", 32'(lin), 32'hFC80);

    run_pixel(rep4(16'h7FFF), lin, relu, leaky, fd);
    chk("sat_pos_lin", 32'(lin), 32'h7FFF);
    chk("sat_pos_leaky", 32'(leaky), 32'h7FFF);

    // -131072 (+128): linear clamps; leaky -16384 fits.
    run_pixel(rep4(16'h8000), lin, relu, leaky, fd);
    chk("sat_neg_lin", 32'(lin), 32'h8000);
    chk("sat_neg_relu", 32'(relu), 32'h0000);
    chk("sat_neg_leaky", 32'(leaky), 32'hC000);

    // Distinct channels exercise both lane groups: 0x0A00 + 0x80.
    run_pixel({16'h0400, 16'h0300, 16'h0200, 16'h0100}, lin, relu, leaky, fd);
    chk("mixed_lin", 32'(lin), 32'h0A80);

    // -1 >>> 3 rounds toward minus infinity.
    run_pixel({16'h0000, 16'h0000, 16'h0000, 16'hFFFF}, lin, relu, leaky, fd);
    chk("round_leaky", 32'(leaky), 32'hFFFF);
    chk("round_lin", 32'(lin), 32'h007F);

    // Frame: fresh counters, frame_done only on the 4th of 5 pixels.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    fd_seen = '0;
    for (int p = 0; p < 5; p++) begin
      run_pixel(rep4(16'(p + 1)), lin, relu, leaky, fd);
      chk("frame_val", 32'(lin), 32'(4 * (p + 1) + 128));
      if (p < 4) fd_seen[p] = fd;
      else chk("frame_p5_done", 32'(fd), 32'd0);
    end
    chk("frame_done_p1to4", 32'(fd_seen), 32'b1000);

    // Backpressure: valid held with new data every cycle; accepts land on cycles 0, 4, 8.
    bp_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      data_in  = rep4(16'((i + 1) * 16));
      valid_in = 1'b1;
      tick();
      if (vout_l) begin
        if (bp_cnt < 3) bp_out[bp_cnt] = dout_l;
        bp_cnt++;
      end
    end
    valid_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (vout_l) bp_cnt++;
    end
    chk("bp_count", 32'(bp_cnt), 32'd3);
    chk("bp_out0", 32'(bp_out[0]), 32'h00C0);
    chk("bp_out1", 32'(bp_out[1]), 32'h01C0);
    chk("bp_out2", 32'(bp_out[2]), 32'h02C0);

    // Reset while ACCUM with g=1: pixel discarded, outputs cleared immediately.
    data_in  = rep4(16'h0100);
    valid_in = 1'b1;
    tick();
    valid_in = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    chk("rst_mid_ready", 32'(rdy_l), 32'd1);
    chk("rst_mid_valid", 32'(vout_l), 32'd0);
    chk("rst_mid_dout", 32'(dout_l), 32'd0);
    tick();
    rst = 1'b0;
    bp_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (vout_l) bp_cnt++;
    end
    chk("rst_mid_no_valid", 32'(bp_cnt), 32'd0);
    run_pixel(rep4(16'h0020), lin, relu, leaky, fd);
    chk("rst_mid_next", 32'(lin), 32'h0100);
    chk("rst_mid_next_fd", 32'(fd), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
